// File: rtl/encrypt_decrypt_if.sv
// Valid/ready data handshake plus key-load handshake bundle for encrypt_decrypt_pipe.
interface encrypt_decrypt_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_mode;
  logic [DATA_W-1:0] out_data;
  logic              key_load;
  logic [DATA_W-1:0] key_in;
  logic              key_ack;

  modport master (
    output in_valid, in_mode, in_data, out_ready, key_load, key_in,
    input  in_ready, out_valid, out_mode, out_data, key_ack
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready, key_load, key_in,
    output in_ready, out_valid, out_mode, out_data, key_ack
  );
endinterface

// File: rtl/encrypt_decrypt_pipe.sv
// Fully pipelined add-rotate keyed cipher: one round per stage, mode carried per word,
// valid/ready backpressure and a key reload that waits for the pipeline to drain.
module encrypt_decrypt_pipe #(
  parameter int                DATA_W  = 8,
  parameter int                ROUNDS  = 3,
  parameter int                ROT     = 3,
  parameter logic [DATA_W-1:0] KEY_RST = DATA_W'(8'hA5)
) (
  input  logic                         clk,
  input  logic                         rst,
  encrypt_decrypt_if.slave             bus,
  output logic [$clog2(ROUNDS+1)-1:0]  occupancy
);
  localparam int OCC_W = $clog2(ROUNDS + 1);

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int n);
    rotl = (x << n) | (x >> (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    rotr = (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] round_key(input logic [DATA_W-1:0] key, input int r);
    round_key = rotl(key, r % DATA_W);
  endfunction

  logic [ROUNDS-1:0]             valid_r;
  logic [ROUNDS-1:0]             mode_r;
  logic [ROUNDS-1:0][DATA_W-1:0] data_r;
  logic [DATA_W-1:0]             key_r;
  logic                          key_ack_r;

  logic [ROUNDS-1:0]             valid_in_s;
  logic [ROUNDS-1:0]             mode_in_s;
  logic [ROUNDS-1:0][DATA_W-1:0] stage_in_s;
  logic [ROUNDS-1:0][DATA_W-1:0] stage_out_s;
  logic [OCC_W-1:0]              occ_s;
  logic                          stall_s;
  logic                          accept_s;

  assign stall_s       = valid_r[ROUNDS-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall_s & ~bus.key_load & ~rst;
  assign accept_s      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = valid_r[ROUNDS-1];
  assign bus.out_mode  = mode_r[ROUNDS-1];
  assign bus.out_data  = data_r[ROUNDS-1];
  assign bus.key_ack   = key_ack_r;
  assign occupancy     = occ_s;

  // Population count of the stage valid bits.
  always_comb begin
    occ_s = '0;
    for (int s = 0; s < ROUNDS; s++) begin
      occ_s = occ_s + OCC_W'(valid_r[s]);
    end
  end

  // Stage inputs: the accepted word (or a bubble) enters stage 0, later stages take their predecessor.
  always_comb begin
    valid_in_s    = '0;
    mode_in_s     = '0;
    stage_in_s    = '0;
    valid_in_s[0] = accept_s;
    mode_in_s[0]  = bus.in_mode;
    stage_in_s[0] = bus.in_data;
    for (int s = 1; s < ROUNDS; s++) begin
      valid_in_s[s] = valid_r[s-1];
      mode_in_s[s]  = mode_r[s-1];
      stage_in_s[s] = data_r[s-1];
    end
  end

  // One cipher round per stage; decrypt walks the round keys in reverse order.
  always_comb begin
    stage_out_s = '0;
    for (int s = 0; s < ROUNDS; s++) begin
      if (mode_in_s[s]) begin
        stage_out_s[s] = rotr(stage_in_s[s], ROT) - round_key(key_r, ROUNDS - 1 - s);
      end else begin
        stage_out_s[s] = rotl(stage_in_s[s] + round_key(key_r, s), ROT);
      end
    end
  end

  // Pipeline registers: shift together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      mode_r  <= '0;
      data_r  <= '0;
    end else if (!stall_s) begin
      valid_r <= valid_in_s;
      mode_r  <= mode_in_s;
      data_r  <= stage_out_s;
    end else begin
      valid_r <= valid_r;
      mode_r  <= mode_r;
      data_r  <= data_r;
    end
  end

  // Key register: only replaced once no word is left in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r     <= KEY_RST;
      key_ack_r <= 1'b0;
    end else if (bus.key_load && (occ_s == '0)) begin
      key_r     <= bus.key_in;
      key_ack_r <= 1'b1;
    end else begin
      key_r     <= key_r;
      key_ack_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_encrypt_decrypt_pipe.sv
// Scoreboard bench for encrypt_decrypt_pipe: default instance (8/3/3) and a 16/5/7 instance.
module tb_encrypt_decrypt_pipe;
  localparam int AW = 8;
  localparam int AR = 3;
  localparam int AROT = 3;
  localparam int BW = 16;
  localparam int BR = 5;
  localparam int BROT = 7;

  typedef struct {
    logic        mode;
    logic [31:0] exp;
    logic [31:0] plain;
    int          cyc;
    bit          rec;
  } sb_t;

  typedef struct {
    logic [31:0] ct;
    logic [31:0] pt;
  } fb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  encrypt_decrypt_if #(.DATA_W(AW)) a_if ();
  encrypt_decrypt_if #(.DATA_W(BW)) b_if ();
  logic [$clog2(AR+1)-1:0] occ_a;
  logic [$clog2(BR+1)-1:0] occ_b;

  encrypt_decrypt_pipe #(.DATA_W(AW), .ROUNDS(AR), .ROT(AROT)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if), .occupancy(occ_a)
  );
  encrypt_decrypt_pipe #(.DATA_W(BW), .ROUNDS(BR), .ROT(BROT)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if), .occupancy(occ_b)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  sb_t qa[$];
  sb_t qb[$];
  fb_t fba[$];
  fb_t fbb[$];
  logic [31:0] key_a, key_b;
  bit acc_a, acc_b, ovr_a, ovr_b, rec_a, rec_b, lat_a, lat_b;
  logic [31:0] ovr_val_a, ovr_val_b;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] msk(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n, input int w);
    logic [31:0] v;
    int k;
    v = x & msk(w);
    k = n % w;
    if (k == 0) return v;
    return ((v << k) | (v >> (w - k))) & msk(w);
  endfunction

  function automatic logic [31:0] enc_ref(input logic [31:0] x, input logic [31:0] key,
                                          input int w, input int rounds, input int rot);
    logic [31:0] v;
    v = x & msk(w);
    for (int s = 0; s < rounds; s++) v = rl((v + rl(key, s, w)) & msk(w), rot, w);
    return v;
  endfunction

  function automatic logic [31:0] dec_ref(input logic [31:0] x, input logic [31:0] key,
                                          input int w, input int rounds, input int rot);
    logic [31:0] v;
    v = x & msk(w);
    for (int s = 0; s < rounds; s++) v = (rl(v, w - (rot % w), w) - rl(key, rounds - 1 - s, w)) & msk(w);
    return v;
  endfunction

  // One clock: sample handshakes after the negedge drive, score, advance to next negedge.
  task automatic tick();
    sb_t e;
    fb_t f;
    bit  rst_now;
    #1;
    rst_now = rst;
    if (a_if.key_ack) key_a = 32'(a_if.key_in);
    if (b_if.key_ack) key_b = 32'(b_if.key_in);
    acc_a = a_if.in_valid && a_if.in_ready;
    acc_b = b_if.in_valid && b_if.in_ready;
    if (acc_a) begin
      e.mode = a_if.in_mode; e.cyc = cyc; e.rec = rec_a; e.plain = 32'(a_if.in_data);
      if (ovr_a) e.exp = ovr_val_a;
      else if (a_if.in_mode) e.exp = dec_ref(32'(a_if.in_data), key_a, AW, AR, AROT);
      else e.exp = enc_ref(32'(a_if.in_data), key_a, AW, AR, AROT);
      qa.push_back(e);
    end
    if (acc_b) begin
      e.mode = b_if.in_mode; e.cyc = cyc; e.rec = rec_b; e.plain = 32'(b_if.in_data);
      if (ovr_b) e.exp = ovr_val_b;
      else if (b_if.in_mode) e.exp = dec_ref(32'(b_if.in_data), key_b, BW, BR, BROT);
      else e.exp = enc_ref(32'(b_if.in_data), key_b, BW, BR, BROT);
      qb.push_back(e);
    end
    if (a_if.out_valid && a_if.out_ready) begin
      check_eq("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check_eq("a_data", 32'(a_if.out_data), e.exp);
        check_eq("a_mode", 32'(a_if.out_mode), 32'(e.mode));
        if (lat_a) check_eq("a_latency", 32'(cyc - e.cyc), 32'(AR));
        if (e.rec) begin f.ct = 32'(a_if.out_data); f.pt = e.plain; fba.push_back(f); end
      end
    end
    if (b_if.out_valid && b_if.out_ready) begin
      check_eq("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check_eq("b_data", 32'(b_if.out_data), e.exp);
        check_eq("b_mode", 32'(b_if.out_mode), 32'(e.mode));
        if (lat_b) check_eq("b_latency", 32'(cyc - e.cyc), 32'(BR));
        if (e.rec) begin f.ct = 32'(b_if.out_data); f.pt = e.plain; fbb.push_back(f); end
      end
    end
    @(negedge clk);
    cyc++;
    if (rst_now) begin
      qa.delete(); qb.delete();
      key_a = 32'hA5; key_b = 32'hA5;
    end
  endtask

  task automatic send(input bit sel, input logic mode, input logic [31:0] data,
                      input bit ovr, input logic [31:0] ovr_val, input bit rec);
    int tries;
    tries = 0;
    if (sel) begin
      b_if.in_valid = 1'b1; b_if.in_mode = mode; b_if.in_data = data[BW-1:0];
      ovr_b = ovr; ovr_val_b = ovr_val; rec_b = rec;
    end else begin
      a_if.in_valid = 1'b1; a_if.in_mode = mode; a_if.in_data = data[AW-1:0];
      ovr_a = ovr; ovr_val_a = ovr_val; rec_a = rec;
    end
    do begin
      tick();
      tries++;
    end while (!(sel ? acc_b : acc_a) && tries < 50);
    check_eq(sel ? "b_send_accept" : "a_send_accept", 32'(sel ? acc_b : acc_a), 32'd1);
    a_if.in_valid = 1'b0; b_if.in_valid = 1'b0;
    ovr_a = 1'b0; ovr_b = 1'b0; rec_a = 1'b0; rec_b = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check_eq("drain_a_empty", 32'(qa.size()), 32'd0);
    check_eq("drain_b_empty", 32'(qb.size()), 32'd0);
    repeat (4) tick();
  endtask

  initial begin
    fb_t f;
    logic [31:0] held;
    int t0, cnt, k;

    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_mode = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
    a_if.key_load = 1'b0; a_if.key_in = '0;
    b_if.in_valid = 1'b0; b_if.in_mode = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b1;
    b_if.key_load = 1'b0; b_if.key_in = '0;
    key_a = 32'hA5; key_b = 32'hA5;
    ovr_a = 1'b0; ovr_b = 1'b0; rec_a = 1'b0; rec_b = 1'b0; lat_a = 1'b1; lat_b = 1'b1;
    ovr_val_a = '0; ovr_val_b = '0;
    @(negedge clk);
    tick();
    tick();
    // Reset state
    check_eq("rst_in_ready_a", 32'(a_if.in_ready), 32'd0);
    check_eq("rst_in_ready_b", 32'(b_if.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check_eq("rst_occupancy", 32'(occ_a), 32'd0);
    check_eq("rst_out_data", 32'(a_if.out_data), 32'd0);
    check_eq("rst_out_mode", 32'(a_if.out_mode), 32'd0);
    check_eq("rst_key_ack", 32'(a_if.key_ack), 32'd0);
    rst = 1'b0;
    a_if.out_ready = 1'b1;

    // Known vector and its inverse, then mixed random traffic
    send(1'b0, 1'b0, 32'h3C, 1'b1, 32'h43, 1'b0);
    send(1'b0, 1'b1, 32'h43, 1'b1, 32'h3C, 1'b0);
    for (int i = 0; i < 200; i++) begin
      send(1'b0, 1'(i % 2), $urandom & 32'hFF, 1'b0, 32'h0, (i % 2) == 0);
    end
    drain();
    t0 = cyc;
    cnt = 0;
    while (fba.size() != 0) begin
      f = fba.pop_front();
      send(1'b0, 1'b1, f.ct, 1'b1, f.pt, 1'b0);
      cnt++;
    end
    check_eq("a_throughput", 32'(cyc - t0), 32'(cnt));
    drain();

    // Backpressure mid-stream
    lat_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1; a_if.in_mode = 1'b0; a_if.in_data = 8'h08;
        held = 32'(a_if.out_data);
        repeat (5) begin
          #1;
          check_eq("stall_in_ready", 32'(a_if.in_ready), 32'd0);
          check_eq("stall_occupancy", 32'(occ_a), 32'd3);
          check_eq("stall_out_valid", 32'(a_if.out_valid), 32'd1);
          check_eq("stall_out_hold", 32'(a_if.out_data), held);
          tick();
        end
        a_if.out_ready = 1'b1;
      end
      send(1'b0, 1'b0, 32'(i), 1'b0, 32'h0, 1'b0);
    end
    drain();

    // Key reload with three words in flight
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 32'h10 + 32'(i), 1'b0, 32'h0, 1'b0);
    a_if.in_valid = 1'b1; a_if.in_mode = 1'b0; a_if.in_data = 8'h77;
    a_if.key_load = 1'b1; a_if.key_in = 8'h5A;
    #1;
    check_eq("key_in_ready", 32'(a_if.in_ready), 32'd0);
    k = 0;
    while (!a_if.key_ack && k < 20) begin
      tick();
      k++;
    end
    check_eq("key_ack_seen", 32'(a_if.key_ack), 32'd1);
    check_eq("key_ack_occupancy", 32'(occ_a), 32'd0);
    check_eq("key_old_results_out", 32'(qa.size()), 32'd0);
    check_eq("key_ack_latency_ok", 32'(k <= AR + 1), 32'd1);
    a_if.key_load = 1'b0;
    send(1'b0, 1'b0, 32'h3C, 1'b1, 32'h65, 1'b0);
    check_eq("key_ack_one_pulse", 32'(a_if.key_ack), 32'd0);
    send(1'b0, 1'b0, 32'hC3, 1'b0, 32'h0, 1'b0);
    drain();

    // Reset mid-stream with a full, stalled pipeline
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 32'h20 + 32'(i), 1'b0, 32'h0, 1'b0);
    check_eq("pre_rst_occupancy", 32'(occ_a), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("post_rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check_eq("post_rst_occupancy", 32'(occ_a), 32'd0);
    a_if.out_ready = 1'b1;
    send(1'b0, 1'b0, 32'h3C, 1'b1, 32'h43, 1'b0);
    drain();

    // Wide instance: encrypt/decrypt round trip and 5-cycle latency
    for (int i = 0; i < 1000; i++) send(1'b1, 1'b0, $urandom & 32'hFFFF, 1'b0, 32'h0, 1'b1);
    drain();
    check_eq("b_fb_count", 32'(fbb.size()), 32'd1000);
    while (fbb.size() != 0) begin
      f = fbb.pop_front();
      send(1'b1, 1'b1, f.ct, 1'b1, f.pt, 1'b0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/encrypt_decrypt_pipe.md
# encrypt_decrypt_pipe

Parametrised, fully pipelined keyed cipher engine that encrypts or decrypts one word per cycle, with the mode selected per transaction. It sits between a producer and a consumer inside the encrypt/decrypt system and replaces the fixed 8-bit, fixed-latency datapath. It adds:
- configurable width, round count and rotate amount;
- valid/ready backpressure on both sides;
- a runtime key-load handshake that drains the pipeline before the key changes.

## Interface
- DATA_W, default 8: data and key width in bits (≥ 4).
- ROUNDS, default 3: number of cipher rounds, equal to the pipeline depth and the latency (≥ 1).
- ROT, default 3: per-round rotate amount (1 ≤ ROT < DATA_W).
- KEY_RST, default 8'hA5 (sized to DATA_W): key value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  engine accepts the input word this cycle.
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled with the input word.
- in_data  in  DATA_W  input word.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts the output word.
- out_mode  out  1  mode carried with the output word.
- out_data  out  DATA_W  result word.
- key_load  in  1  key change request; held until key_ack.
- key_in  in  DATA_W  new key; held stable while key_load is high.
- key_ack  out  1  one-cycle pulse; key register updated this edge.
- occupancy  out  $clog2(ROUNDS+1)  number of valid stages in the pipeline.

## Operation
- Round keys: k_r = rotl(key, r mod DATA_W), for r = 0..ROUNDS-1.
- Encrypt round at stage s: y = rotl((x + k_s) mod 2^DATA_W, ROT).
- Decrypt round at stage s: y = (rotr(x, ROT) − k_(ROUNDS-1-s)) mod 2^DATA_W.
- Decrypt is the exact inverse of encrypt under the same key.
- Each stage holds a valid bit, a mode bit and a data register.
- Mode travels with the data, so mixed encrypt/decrypt traffic is legal back to back.
- stall = out_valid & ~out_ready.
  - When stall is low, every stage shifts one place, and a bubble enters stage 0 if no word is accepted.
  - When stall is high, every stage holds.
  - Bubbles are not collapsed.
- in_ready = ~stall & ~key_load. A word is accepted when in_valid & in_ready.
- Key handshake:
  - key_load high blocks new input, and the pipeline drains.
  - On the first edge with occupancy == 0 and key_load high, the engine does key ← key_in and pulses key_ack for one cycle.
  - key_ack is never asserted while any stage is valid.
  - The requester drops key_load the cycle after key_ack. If key_load is still high, a further load occurs the next cycle (same value, harmless).
- occupancy is the count of set stage valid bits, updated combinationally from the registers.
- Reset values:
  - all stage valid bits 0, so out_valid 0 and occupancy 0;
  - out_data 0, out_mode 0;
  - key_ack 0;
  - key = KEY_RST.
- in_ready is 0 during the reset cycle.
- Reset mid-operation discards every in-flight word; no partial output appears after reset.

## Timing
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N+ROUNDS, provided there is no stall.
- Throughput: one word per cycle under continuous in_valid & out_ready.
- A stall of S cycles delays every in-flight word by S cycles. in_ready returns the same cycle out_ready rises (combinational path out_ready → in_ready).
- out_data, out_mode and out_valid are registered and stay stable while stall is high.
- Key load latency: key_ack occurs max(1, cycles to drain) edges after key_load rises. The drain takes at most ROUNDS cycles with no stall.
- The first word accepted after key_ack uses the new key.
- Simultaneous key_load and in_valid: the key takes priority and the word is not accepted.

## Test plan
- Defaults (DATA_W=8, ROUNDS=3, ROT=3, key 0xA5), encrypt 0x3C with out_ready=1 → out_data 0x43, out_mode 0, out_valid exactly 3 cycles after acceptance.
- Decrypt 0x43, then 200 random words alternating mode every cycle → decrypt returns 0x3C. Each encrypted word fed back in decrypt mode reproduces the original; output order is preserved and there is one output per cycle.
- Backpressure: stream 0x00..0x0F, hold out_ready=0 for 5 cycles mid-stream → in_ready drops, out_data holds, no word is lost or duplicated, occupancy = 3 during the stall.
- Key reload with 3 words in flight: key_load with key_in 0x5A → in_ready 0. The 3 old-key results emerge, then key_ack pulses with occupancy 0. Encrypt 0x3C under the new key matches the reference-model value.
- Reset mid-stream: assert rst for 1 cycle with occupancy 3 → out_valid 0 and occupancy 0 on the next cycle, key back to 0xA5, and no stale outputs afterwards.
- Parameter sweep: DATA_W=16, ROUNDS=5, ROT=7 → encrypt/decrypt round trip holds for 1000 random words, and latency is 5 cycles.
